// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/access memory port arbiter.
// State and owner encodings are reused by the pipeline controllers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/access controllers, arbiter and memory.
// master = arbiter side, slave = requesters plus memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// Counts BUSY cycles and flags the cycle an unanswered access must abort.
// TIMEOUT of 0 disables the abort entirely.
module arb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (en) begin
      wait_cnt <= wait_cnt + W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && en &&
                   (wait_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory shared by fetch (I) and access (D) stages.
// IDLE -> BUSY -> RESP, with bounded fetch starvation and abort.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.master bus
);

  localparam logic [STARVE_W-1:0] LIM =
    STARVE_W'(STARVE_LIM);

  arb_state_t          state;
  arb_owner_t          owner;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [STARVE_W-1:0] starve_cnt;

  logic i_win;
  logic d_win;
  logic can_gnt;
  logic expired;

  // Grants are gated by reset so nothing is accepted while held.
  assign i_win   = bus.if_req &&
                   (!bus.d_req || starve_cnt == LIM);
  assign d_win   = bus.d_req && !i_win;
  assign can_gnt = rst && (state == ST_IDLE);

  assign bus.if_gnt = can_gnt && i_win;
  assign bus.d_gnt  = can_gnt && d_win;

  arb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_BUSY),
    .en      (state == ST_BUSY),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.if_gnt) begin
            owner      <= OWN_I;
            we_q       <= 1'b0;
            addr_q     <= bus.if_addr;
            wdata_q    <= '0;
            starve_cnt <= '0;
            state      <= ST_BUSY;
          end else if (bus.d_gnt) begin
            owner   <= OWN_D;
            we_q    <= bus.d_we;
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
            state   <= ST_BUSY;
            if (!bus.if_req)
              starve_cnt <= '0;
            else if (starve_cnt != LIM)
              starve_cnt <= starve_cnt + STARVE_W'(1);
          end
        end
        ST_BUSY: begin
          if (bus.mem_ready) begin
            rdata_q <= we_q ? '0 : bus.mem_rdata;
            err_q   <= 1'b0;
            state   <= ST_RESP;
          end else if (expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = (state == ST_BUSY);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.if_rvalid = (state == ST_RESP) &&
                         (owner == OWN_I);
  assign bus.d_rvalid  = (state == ST_RESP) &&
                         (owner == OWN_D);
  assign bus.if_rdata  = rdata_q;
  assign bus.d_rdata   = rdata_q;
  assign bus.if_err    = err_q;
  assign bus.d_err     = err_q;

  assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
// Model tracks pending requests, starvation count and expected responses.
module tb_mem_port_arbiter;

  localparam int LIM = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_LIM (LIM),
    .TIMEOUT    (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  int          starve = 0;
  bit          pend_i = 0;
  bit          pend_d = 0;
  logic [31:0] pi_addr;
  logic [31:0] pd_addr;
  logic [31:0] pd_wdata;
  logic        pd_we;
  bit          gnt_log[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic new_i();
    pend_i  = 1;
    pi_addr = $urandom;
  endtask

  task automatic new_d();
    pend_d   = 1;
    pd_addr  = $urandom;
    pd_we    = 1'($urandom % 2);
    pd_wdata = $urandom;
  endtask

  // Non-pending payload lines carry noise; only grants may sample them.
  task automatic drive_reqs();
    bus.if_req  = pend_i;
    bus.if_addr = pend_i ? pi_addr : $urandom;
    bus.d_req   = pend_d;
    bus.d_addr  = pend_d ? pd_addr : $urandom;
    bus.d_we    = pend_d ? pd_we : 1'($urandom % 2);
    bus.d_wdata = pend_d ? pd_wdata : $urandom;
  endtask

  // Entered at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic do_txn(input int lat,
                        input logic [31:0] rdv);
    bit          own_d;
    bit          done;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd_exp;
    bit          err_exp;
    int          req_cyc;
    drive_reqs();
    #1;
    chk("idle_busy", bus.busy, 0);
    own_d = pend_d && !(pend_i && starve == LIM);
    chk("if_gnt", bus.if_gnt, !own_d);
    chk("d_gnt", bus.d_gnt, own_d);
    gnt_log.push_back(own_d);
    if (own_d) begin
      we     = pd_we;
      addr   = pd_addr;
      wd     = pd_wdata;
      starve = pend_i ? ((starve < LIM) ? starve + 1 : LIM) : 0;
      pend_d = 0;
    end else begin
      we     = 1'b0;
      addr   = pi_addr;
      wd     = '0;
      starve = 0;
      pend_i = 0;
    end
    done    = 0;
    req_cyc = 0;
    rd_exp  = '0;
    err_exp = 0;
    for (int k = 0; k < TMO && !done; k++) begin
      @(negedge clk);
      drive_reqs();
      bus.mem_ready = (k == lat);
      bus.mem_rdata = rdv;
      #1;
      req_cyc += int'(bus.mem_req);
      chk("mem_req", bus.mem_req, 1);
      chk("mem_addr", bus.mem_addr, addr);
      chk("mem_we", bus.mem_we, we);
      chk("mem_wdata", bus.mem_wdata, wd);
      chk("busy_gnt", {bus.if_gnt, bus.d_gnt}, 0);
      if (k == lat) begin
        rd_exp  = we ? '0 : rdv;
        err_exp = 0;
        done    = 1;
      end else if (k == TMO - 1) begin
        rd_exp  = '0;
        err_exp = 1;
        done    = 1;
      end
    end
    chk("req_cycles", req_cyc,
        (lat < TMO) ? lat + 1 : TMO);
    @(negedge clk);
    drive_reqs();
    bus.mem_ready = 1'($urandom % 2);
    bus.mem_rdata = $urandom;
    #1;
    chk("resp_mem_req", bus.mem_req, 0);
    chk("resp_busy", bus.busy, 1);
    chk("resp_gnt", {bus.if_gnt, bus.d_gnt}, 0);
    chk("if_rvalid", bus.if_rvalid, !own_d);
    chk("d_rvalid", bus.d_rvalid, own_d);
    if (own_d) begin
      chk("d_rdata", bus.d_rdata, rd_exp);
      chk("d_err", bus.d_err, err_exp);
    end else begin
      chk("if_rdata", bus.if_rdata, rd_exp);
      chk("if_err", bus.if_err, err_exp);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 11);
    if (r < 8) return r % 4;
    if (r == 8) return TMO - 1;
    if (r == 9) return 99;
    return r % 3;
  endfunction

  initial begin
    rst           = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    pi_addr       = 32'h0000_0040;
    pend_i        = 1;
    drive_reqs();

    // Reset held with a fetch pending: everything quiet.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_flags",
        {bus.if_gnt, bus.d_gnt, bus.if_rvalid,
         bus.d_rvalid, bus.if_err, bus.d_err,
         bus.mem_req, bus.mem_we, bus.busy}, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);

    @(negedge clk);
    rst = 1'b1;
    do_txn(1, $urandom);

    // D read, ready two cycles after mem_req rises.
    pend_d  = 1;
    pd_we   = 0;
    pd_addr = 32'h0000_0100;
    pd_wdata = $urandom;
    do_txn(2, 32'hDEAD_BEEF);

    // D write.
    pend_d   = 1;
    pd_we    = 1;
    pd_addr  = 32'h0000_0200;
    pd_wdata = 32'h55AA_55AA;
    do_txn(3, $urandom);

    // Both held continuously: D,D,D,D,I,...
    gnt_log.delete();
    for (int j = 0; j < 10; j++) begin
      if (!pend_i) new_i();
      if (!pend_d) new_d();
      do_txn($urandom_range(0, 2), $urandom);
    end
    for (int j = 0; j < 10; j++)
      chk("order", gnt_log[j], (j % 5) != 4);
    pend_i = 0;
    pend_d = 0;

    // Memory never answers, then normal service.
    pend_d = 1;
    pd_we  = 0;
    pd_addr = 32'h0000_0300;
    do_txn(99, $urandom);
    new_i();
    do_txn(0, $urandom);

    // Reset during BUSY drops the access.
    new_d();
    drive_reqs();
    #1;
    chk("mid_d_gnt", bus.d_gnt, 1);
    pend_d = 0;
    @(negedge clk);
    drive_reqs();
    bus.mem_ready = 1'b0;
    #1;
    chk("mid_mem_req", bus.mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", bus.mem_req, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rv",
        {bus.if_rvalid, bus.d_rvalid}, 0);
    @(negedge clk);
    chk("mid_rst_rv2",
        {bus.if_rvalid, bus.d_rvalid}, 0);
    rst    = 1'b1;
    starve = 0;
    new_i();
    do_txn(1, $urandom);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      if (!pend_i && ($urandom % 2)) new_i();
      if (!pend_d && ($urandom % 2)) new_d();
      if (!pend_i && !pend_d) begin
        if ($urandom % 2) new_i();
        else new_d();
      end
      do_txn(pick_lat(), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
